// File: rtl/html_char_reader_pkg.sv
// html_char_reader_pkg: character width, default terminator and casefold helper shared with html_parser
package html_char_reader_pkg;
  localparam int CHAR_BITES = 8;
  localparam logic [CHAR_BITES-1:0] CHAR_TERMINATOR = 8'h00;
  function automatic logic [CHAR_BITES-1:0] fold_char(input logic [CHAR_BITES-1:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c;
  endfunction
endpackage

// File: rtl/html_char_reader_if.sv
// html_char_reader_if: ROM read port plus parser-facing character port of the reader
interface html_char_reader_if #(parameter int ADDR_WIDTH = 12);
  import html_char_reader_pkg::*;
  logic                  next_char;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_rden;
  logic [7:0]            rom_data;
  logic [CHAR_BITES-1:0] char;
  logic                  char_valid;
  logic                  eof;
  modport master (
    input  next_char, rom_data,
    output rom_addr, rom_rden, char, char_valid, eof
  );
  modport slave (
    output next_char, rom_data,
    input  rom_addr, rom_rden, char, char_valid, eof
  );
endinterface

// File: rtl/html_char_reader_char_fifo2.sv
// char_fifo2: two-entry shift FIFO, head reads as zero when empty
module char_fifo2 #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic pop;
  always_comb begin
    pop = pop_i & (count_q != 2'd0);
    e0_d = pop ? e1_q : e0_q;
    e1_d = e1_q;
    count_d = pop ? count_q - 2'd1 : count_q;
    if (push_i && count_d != 2'd2) begin
      e0_d = (count_d == 2'd0) ? din_i : e0_d;
      e1_d = (count_d == 2'd1) ? din_i : e1_d;
      count_d = count_d + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign head_o = (count_q != 2'd0) ? e0_q : '0;
  assign count_o = count_q;
endmodule

// File: rtl/html_char_reader.sv
// html_char_reader: streams ROM text to the parser via a 2-deep prefetch; HTML_READER_CASEFOLD_EN lowercases A-Z
module html_char_reader
  import html_char_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TEXT_LENGTH = 4096,
  parameter logic [CHAR_BITES-1:0] TERMINATOR = CHAR_TERMINATOR
) (
  input logic CLOCK_50,
  input logic reset,
  html_char_reader_if.master bus
);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(TEXT_LENGTH);
  logic [ADDR_WIDTH:0] faddr_q, faddr_d;
  logic inflight_q, inflight_d, done_q, done_d;
  logic [1:0] count;
  logic [CHAR_BITES-1:0] head, push_data;
  logic pop, push, term_hit, issue;
  assign pop = bus.next_char & bus.char_valid;
  assign term_hit = inflight_q & (bus.rom_data == TERMINATOR);
  // a terminator on the ROM bus already stops the next fetch, so eof is not held off by a wasted read
  assign issue = !reset & !done_q & !term_hit & (faddr_q < LIMIT) &
                 ({1'b0, count} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
  assign push = inflight_q & !term_hit & !done_q;
`ifdef HTML_READER_CASEFOLD_EN
  assign push_data = fold_char(bus.rom_data);
`else
  assign push_data = bus.rom_data;
`endif
  always_comb begin
    faddr_d = issue ? faddr_q + (ADDR_WIDTH+1)'(1) : faddr_q;
    inflight_d = issue;
    done_d = done_q | term_hit | (faddr_q == LIMIT);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      faddr_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      faddr_q <= faddr_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
    end
  end
  char_fifo2 #(.W(CHAR_BITES)) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_data),
    .head_o  (head),
    .count_o (count)
  );
  assign bus.rom_addr = faddr_q[ADDR_WIDTH-1:0];
  assign bus.rom_rden = issue;
  assign bus.char = head;
  assign bus.char_valid = count != 2'd0;
  assign bus.eof = done_q & !inflight_q & (count == 2'd0);
endmodule

// File: tb/tb_html_char_reader.sv
// tb_html_char_reader: scoreboard bench for html_char_reader against a text-level reference model
module tb_html_char_reader;
  localparam int AW = 5;
  localparam int TL = 20;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  html_char_reader_if #(.ADDR_WIDTH(AW)) bus ();
  html_char_reader #(.ADDR_WIDTH(AW), .TEXT_LENGTH(TL), .TERMINATOR(8'h00)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );
  logic [7:0] rom [DEPTH];
  logic [7:0] exp_q [$];
  int checks = 0;
  int fails = 0;
  int pops = 0;
  always @(posedge clk) if (bus.rom_rden) bus.rom_data <= rom[bus.rom_addr];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask
  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef HTML_READER_CASEFOLD_EN
    if (c >= 8'h41 && c <= 8'h5a) return c + 8'd32;
`endif
    return c;
  endfunction
  // the parser should see every byte before the first terminator, capped at the text length
  task automatic expect_text();
    exp_q.delete();
    for (int i = 0; i < TL && rom[i] != 8'h00; i++) exp_q.push_back(fold(rom[i]));
  endtask
  task automatic load_str(input string s);
    for (int i = 0; i < DEPTH; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask
  task automatic start(input int n);
    rst = 1'b1;
    expect_text();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_eof(input int budget, input bit rnd);
    int n = 0;
    while (!bus.eof && n < budget) begin
      @(posedge clk);
      #1 bus.next_char = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
    check("eof_reached", bus.eof, 1);
    check("stream_drained", exp_q.size(), 0);
    check("char_zero_at_eof", bus.char, 0);
  endtask
  task automatic eof_stable();
    logic [AW-1:0] addr;
    addr = bus.rom_addr;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 bus.next_char = i[0];
      @(negedge clk);
      check("eof_sticky", bus.eof, 1);
      check("eof_valid_low", bus.char_valid, 0);
      check("eof_rden_low", bus.rom_rden, 0);
      check("eof_addr_stable", bus.rom_addr, addr);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.char_valid && bus.next_char) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL char_extra: got 0x%0h, required no character", bus.char);
        end else check("char", bus.char, exp_q.pop_front());
      end
      if (!bus.char_valid) check("char_idle_zero", bus.char, 0);
      if (bus.rom_rden) check("rom_addr_limit", 32'(bus.rom_addr < TL), 1);
    end
  end
  initial begin
    int rden_cnt;
    int base;
    int n;
    bus.next_char = 1'b0;
    load_str("ab<p>");
    expect_text();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rden", bus.rom_rden, 0);
    check("rst_char_valid", bus.char_valid, 0);
    check("rst_char", bus.char, 0);
    check("rst_eof", bus.eof, 0);
    check("rst_addr", bus.rom_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("pre_e0_rden", bus.rom_rden, 1);
    check("pre_e0_addr", bus.rom_addr, 0);
    rden_cnt = 32'(bus.rom_rden);
    @(negedge clk);
    check("e0_char_valid", bus.char_valid, 0);
    rden_cnt += 32'(bus.rom_rden);
    @(negedge clk);
    check("e1_char_valid", bus.char_valid, 1);
    check("e1_char", bus.char, 8'h61);
    rden_cnt += 32'(bus.rom_rden);
    repeat (10) begin
      @(negedge clk);
      rden_cnt += 32'(bus.rom_rden);
    end
    check("idle_rden_pulses", rden_cnt, 2);
    check("idle_addr", bus.rom_addr, 2);
    check("idle_char", bus.char, 8'h61);
    wait_eof(40, 1'b0);
    eof_stable();
    @(posedge clk);
    #1 bus.next_char = 1'b1;
    start(1);
    repeat (7) @(negedge clk);
    check("last_char_gt", bus.char, 8'h3e);
    check("eof_before_last_pop", bus.eof, 0);
    @(negedge clk);
    check("eof_on_last_pop", bus.eof, 1);
    check("valid_after_last_pop", bus.char_valid, 0);
    @(posedge clk);
    #1 start(1);
    base = pops;
    n = 0;
    while (pops < base + 3 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("three_pops_seen", pops - base, 3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    expect_text();
    @(negedge clk);
    check("midrst_char_valid", bus.char_valid, 0);
    check("midrst_eof", bus.eof, 0);
    check("midrst_addr", bus.rom_addr, 0);
    wait_eof(40, 1'b0);
    eof_stable();
    load_str("<HTML>");
    @(posedge clk);
    #1 start(2);
    wait_eof(100, 1'b1);
    load_str("abcdefghijklmnopqrstuvwxyz");
    @(posedge clk);
    #1 start(1);
    wait_eof(200, 1'b1);
    check("length_limit_addr", bus.rom_addr, TL);
    for (int t = 0; t < 40; t++) begin
      int p;
      for (int i = 0; i < DEPTH; i++)
        rom[i] = ($urandom_range(0, 2) == 0) ? 8'(8'h41 + $urandom_range(0, 25)) : 8'($urandom_range(1, 255));
      p = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) rom[p] = 8'h00;
      @(posedge clk);
      #1 start($urandom_range(1, 3));
      wait_eof(300, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
